alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Single-issue execute controller for the 16-bit datapath. Accepts instruction words over a valid/ready handshake and decodes them into the ALU opcode and operand buses. Closes the loop on the ALU's result and ZCFNL flags, writing back to an internal 16×16 register file and a processor status register (PSR). Sits between instruction fetch and the combinational ALU; it is the ALU's only driver.

## Interface
- `DATA_W`, 16, datapath width
- `REG_COUNT`, 16, register file depth (4-bit register fields)
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `instr_valid` in 1: instruction word present
- `instr` in 16: `[15:12]` class, `[11:8]` Rdest, `[7:4]` ext/immHi, `[3:0]` Rsrc/immLo
- `instr_ready` out 1: block can accept an instruction
- `alu_opcode` out 8: `{instr[15:12], instr[7:4]}`
- `alu_a` out 16: R[Rdest]
- `alu_b` out 16: R[Rsrc] or extended immediate
- `alu_cin` out 1: PSR[3]
- `alu_c` in 16: ALU result
- `alu_flags` in 5: ALU ZCFNL flags
- `psr` out 5: status register (Z=4, C=3, F=2, N=1, L=0)
- `done_valid` out 1: one-cycle retire pulse
- `done_data` out 16: value written to Rdest (0 when no write)
- `dbg_raddr` in 4, `dbg_rdata` out 16: combinational register-file read port

## Operation
- Clock is `clk`. Reset is `reset`: one clock, synchronous and active-high. Reset clears all registers, PSR, `done_*` and ALU output buses to 0, sets state to IDLE and raises `instr_ready`.
- FSM states are IDLE → DECODE → EXEC → WB → IDLE.
  - IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and go to DECODE.
  - DECODE: read operands and register `alu_opcode`/`alu_a`/`alu_b`/`alu_cin`.
  - EXEC: ALU settles. Register `alu_c` and `alu_flags` into holding registers.
  - WB: commit per class, pulse `done_valid`, return to IDLE.
- Class 0000 (register ALU ops):
  - `alu_b`=R[Rsrc].
  - Writes Rdest and PSR, except ext 1011/1111 (CMP/CMPU), which update PSR only.
  - ext 0000 (NOP): no write, PSR unchanged.
- Classes 0101 (ADDI) and 0111 (ADDCI): `alu_b`=sign-extended `instr[7:0]`. Write Rdest and PSR.
- Class 0110 (ADDUI): `alu_b`=zero-extended `instr[7:0]`. Write Rdest and PSR.
- Class 1000 (shifts):
  - ext 0000/0001 (LSHI): `alu_b`=zero-extended `instr[3:0]`.
  - ext 0100 (LSH): `alu_b`=R[Rsrc].
  - Write Rdest and PSR.
- Class 1111 (MOVI): Rdest ← zero-extended `instr[7:0]`. The ALU result is ignored and PSR is unchanged.
- All other classes act as NOP: no write, PSR unchanged, `done_valid` still pulses.
- `alu_cin` always reflects PSR at DECODE. Flags written by instruction N are visible to instruction N+1.
- `done_data`/`done_valid` are registered. `done_data` holds until the next retire.

## Timing
- Latency: instruction accepted at edge 0 → `done_valid` high for the cycle after edge 3 → register/PSR updated at edge 3.
- Throughput is one instruction per 4 cycles. `instr_ready` is low in DECODE/EXEC/WB.
- `instr_valid` while not ready is ignored. The producer must hold the word until a cycle where ready and valid are both high.
- `dbg_rdata` shows pre-write contents in the WB cycle and new contents from the following cycle.
- Reset in any state aborts the in-flight instruction: no write, no PSR update, no `done_valid`.

## Configuration
- `ALU_CTRL_FAST_EN` defined: the DECODE state is removed. Operands are read and ALU buses registered on the accept edge. Latency is 3 cycles and throughput one per 3 cycles.
- Undefined: the 4-state FSM above, with latency 4.

## Structure
- Package `alu_ctrl_pkg` holds:
  - state enum;
  - class constants (CLS_RR, CLS_ADDI, CLS_ADDUI, CLS_ADDCI, CLS_SHIFT, CLS_MOVI);
  - ext constants (EXT_NOP, EXT_CMP, EXT_CMPU, EXT_LSHI, EXT_LSH);
  - PSR bit indices.
- Sub-module `alu_ctrl_regfile` has two sync-written / async-read operand ports plus the debug port, one write port, and reset-to-zero.

## Test plan
- Bench closes the loop with the team ALU.
- Load: MOVI R1,#5 (0xF105), MOVI R2,#3 (0xF203) → `dbg_rdata` R1=0x0005, R2=0x0003, `done_data` 5 then 3, `psr`=00000.
- ADD 0x0152 → in EXEC `alu_opcode`=0x05, `alu_a`=5, `alu_b`=3. Then R1=0x0008, `done_valid` exactly 4 cycles after accept.
- SUB 0x0291 → R2=0xFFFB. CMP 0x01B2 → R1 stays 8, `psr`=00000. CMPU 0x01F2 → `psr`=00001, `done_data`=0.
- MOVI R3,#5 (0xF305); ADDU 0x0263 → R2=0x0000, `psr[4]`=1, `psr[3]`=1. ADDC 0x0173 → `alu_cin`=1, R1=0x000E.
- ADDI 0x51FE → `alu_opcode`=0x5F, `alu_b`=0xFFFE. Back-to-back `instr_valid` is accepted only when `instr_ready`=1.
- `reset` pulsed during EXEC of ADD → R1 unchanged (0 after reset), no `done_valid`, `instr_ready`=1 the next cycle. Repeat with `ALU_CTRL_FAST_EN`: latency is 3.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and encodings for the ALU execute controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

  localparam int RADDR_W = 4;
  localparam int PSR_W   = 5;

  // PSR bit positions
  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_F = 2;
  localparam int PSR_N = 1;
  localparam int PSR_L = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Instruction class field, instr[15:12]
  localparam logic [3:0] CLS_RR    = 4'b0000;
  localparam logic [3:0] CLS_ADDI  = 4'b0101;
  localparam logic [3:0] CLS_ADDUI = 4'b0110;
  localparam logic [3:0] CLS_ADDCI = 4'b0111;
  localparam logic [3:0] CLS_SHIFT = 4'b1000;
  localparam logic [3:0] CLS_MOVI  = 4'b1111;

  // Extension field, instr[7:4]
  localparam logic [3:0] EXT_NOP  = 4'b0000;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_CMPU = 4'b1111;
  localparam logic [3:0] EXT_LSHI = 4'b0000;  // 0000 and 0001 both encode LSHI
  localparam logic [3:0] EXT_LSH  = 4'b0100;

  typedef struct packed {
    logic wr_reg;
    logic wr_psr;
  } commit_t;

  // LSHI uses the low ext bit as part of the shift encoding, so match on [3:1]
  function automatic logic is_lshi(input logic [3:0] ext);
    return ext[3:1] == EXT_LSHI[3:1];
  endfunction

  // What a retiring instruction is allowed to update
  function automatic commit_t commit_kind(input logic [3:0] cls, input logic [3:0] ext);
    commit_t k;
    k = '0;
    case (cls)
      CLS_RR: begin
        if (ext == EXT_CMP || ext == EXT_CMPU) begin
          k.wr_psr = 1'b1;
        end else if (ext != EXT_NOP) begin
          k.wr_reg = 1'b1;
          k.wr_psr = 1'b1;
        end
      end
      CLS_ADDI, CLS_ADDUI, CLS_ADDCI, CLS_SHIFT: begin
        k.wr_reg = 1'b1;
        k.wr_psr = 1'b1;
      end
      CLS_MOVI: k.wr_reg = 1'b1;
      default:  k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// alu_ctrl_regfile: REG_COUNT x DATA_W register file, two operand read ports, debug read port, one write port.
// Latency: reads combinational; write visible the cycle after the write edge.
// Backpressure: none; write enable is taken every cycle.
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] ra_addr_i,
  input  logic [RADDR_W-1:0] rb_addr_i,
  input  logic [RADDR_W-1:0] dbg_addr_i,
  input  logic               wr_en_i,
  input  logic [RADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  output logic [DATA_W-1:0]  ra_data_o,
  output logic [DATA_W-1:0]  rb_data_o,
  output logic [DATA_W-1:0]  dbg_data_o
);

  logic [DATA_W-1:0] mem_q [REG_COUNT];

  // Storage: cleared by reset, single write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign ra_data_o  = mem_q[ra_addr_i];
  assign rb_data_o  = mem_q[rb_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: decodes instruction words, drives the combinational ALU, writes result to regfile and flags to PSR.
// Latency: accept to done_valid 4 cycles; 3 cycles when ALU_CTRL_FAST_EN is defined (DECODE state removed).
// Backpressure: instr_ready high only in IDLE; instr_valid while busy is ignored and the producer must hold the word.
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [15:0]        instr,
  output logic               instr_ready,
  output logic [7:0]         alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic [PSR_W-1:0]   alu_flags,
  output logic [PSR_W-1:0]   psr,
  output logic               done_valid,
  output logic [DATA_W-1:0]  done_data,
  input  logic [RADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
);

  state_e            state_q, state_d;
  logic              accept, load_alu, capture, commit;
  logic [15:0]       instr_q, dec_instr;
  logic [3:0]        dec_cls, dec_ext;
  logic [DATA_W-1:0] ra_data, rb_data, opb_d;
  logic [DATA_W-1:0] imm8_sext, imm8_zext, imm4_zext, movi_data, wb_data;
  logic [7:0]        alu_opcode_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, c_hold_q, done_data_q;
  logic              alu_cin_q, done_valid_q;
  logic [PSR_W-1:0]  flags_hold_q, psr_q;
  commit_t           wb_kind;
  logic              rf_we;

  // Operands are read from the incoming word when DECODE is skipped, otherwise from the latched copy
`ifdef ALU_CTRL_FAST_EN
  assign dec_instr = instr;
`else
  assign dec_instr = instr_q;
`endif

  assign dec_cls   = dec_instr[15:12];
  assign dec_ext   = dec_instr[7:4];
  assign imm8_sext = {{(DATA_W-8){dec_instr[7]}}, dec_instr[7:0]};
  assign imm8_zext = {{(DATA_W-8){1'b0}}, dec_instr[7:0]};
  assign imm4_zext = {{(DATA_W-4){1'b0}}, dec_instr[3:0]};

  alu_ctrl_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .ra_addr_i  (dec_instr[11:8]),
    .rb_addr_i  (dec_instr[3:0]),
    .dbg_addr_i (dbg_raddr),
    .wr_en_i    (rf_we),
    .wr_addr_i  (instr_q[11:8]),
    .wr_data_i  (wb_data),
    .ra_data_o  (ra_data),
    .rb_data_o  (rb_data),
    .dbg_data_o (dbg_rdata)
  );

  // Operand B select: register or extended immediate depending on class
  always_comb begin
    opb_d = rb_data;
    case (dec_cls)
      CLS_ADDI, CLS_ADDCI: opb_d = imm8_sext;
      CLS_ADDUI, CLS_MOVI: opb_d = imm8_zext;
      CLS_SHIFT:           opb_d = is_lshi(dec_ext) ? imm4_zext : rb_data;
      default:             opb_d = rb_data;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    load_alu    = 1'b0;
    capture     = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept = 1'b1;
`ifdef ALU_CTRL_FAST_EN
          load_alu = 1'b1;
          state_d  = ST_EXEC;
`else
          state_d  = ST_DECODE;
`endif
        end
      end
      ST_DECODE: begin
        load_alu = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb_kind   = commit_kind(instr_q[15:12], instr_q[7:4]);
  assign movi_data = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
  // MOVI bypasses the ALU entirely
  assign wb_data   = (instr_q[15:12] == CLS_MOVI) ? movi_data : c_hold_q;
  assign rf_we     = commit && wb_kind.wr_reg;

  // Datapath registers: instruction latch, ALU drive, result holding, PSR and retire
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      c_hold_q     <= '0;
      flags_hold_q <= '0;
      psr_q        <= '0;
      done_valid_q <= 1'b0;
      done_data_q  <= '0;
    end else begin
      done_valid_q <= 1'b0;
      if (accept) begin
        instr_q <= instr;
      end
      if (load_alu) begin
        alu_opcode_q <= {dec_cls, dec_ext};
        alu_a_q      <= ra_data;
        alu_b_q      <= opb_d;
        alu_cin_q    <= psr_q[PSR_C];
      end
      if (capture) begin
        c_hold_q     <= alu_c;
        flags_hold_q <= alu_flags;
      end
      if (commit) begin
        done_valid_q <= 1'b1;
        done_data_q  <= wb_kind.wr_reg ? wb_data : '0;
        if (wb_kind.wr_psr) begin
          psr_q <= flags_hold_q;
        end
      end
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign psr        = psr_q;
  assign done_valid = done_valid_q;
  assign done_data  = done_data_q;

endmodule
